// File: rtl/lcd_pause_sched_if.sv
// Pointer, enable and pause/status bundle between the LCD framebuffer block,
// the pause scheduler and the two GB cores.
interface lcd_pause_sched_if;
  logic        link_lock;
  logic        out_vs;
  logic        core1_on;
  logic        core2_on;
  logic [14:0] core1_wr_ptr;
  logic [14:0] core2_wr_ptr;
  logic [14:0] out_ptr1;
  logic [14:0] out_ptr2;
  logic        pause1;
  logic        pause2;
  logic [1:0]  state1;
  logic [1:0]  state2;
  logic [7:0]  hits1;
  logic [7:0]  hits2;

  modport master (
    output link_lock, out_vs, core1_on, core2_on,
           core1_wr_ptr, core2_wr_ptr, out_ptr1, out_ptr2,
    input  pause1, pause2, state1, state2, hits1, hits2
  );

  modport slave (
    input  link_lock, out_vs, core1_on, core2_on,
           core1_wr_ptr, core2_wr_ptr, out_ptr1, out_ptr2,
    output pause1, pause2, state1, state2, hits1, hits2
  );
endinterface

// File: rtl/lcd_pause_sched.sv
// Per-core pause scheduler: holds a GB core in a timed pause whenever its
// framebuffer writer is too far ahead of scanout at the check line.
module lcd_pause_sched #(
  parameter logic [14:0] TRIG_OUT = 15'd11521,
  parameter logic [14:0] TRIG_IN  = 15'd4801,
  parameter logic [7:0]  HOLD_LEN = 8'd255
) (
  input logic              clk_sys,
  input logic              reset,
  lcd_pause_sched_if.slave bus
);

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_SYNC  = 2'd1,
    S_TRACK = 2'd2,
    S_HOLD  = 2'd3
  } state_e;

  state_e      state_q [2];
  state_e      state_d [2];
  logic [7:0]  cnt_q   [2];
  logic [7:0]  cnt_d   [2];
  logic [7:0]  hits_q  [2];
  logic [7:0]  hits_d  [2];
  logic [14:0] wr_ptr  [2];
  logic [14:0] rd_ptr  [2];
  logic [1:0]  on;
  logic [1:0]  need;
  logic [1:0]  req_d;
  logic [1:0]  pause_q;
  logic [1:0]  pause_d;

  assign on        = {bus.core2_on, bus.core1_on};
  assign wr_ptr[0] = bus.core1_wr_ptr;
  assign wr_ptr[1] = bus.core2_wr_ptr;
  assign rd_ptr[0] = bus.out_ptr1;
  assign rd_ptr[1] = bus.out_ptr2;
  assign need[0]   = (rd_ptr[0] == TRIG_OUT) && (wr_ptr[0] > TRIG_IN);
  assign need[1]   = (rd_ptr[1] == TRIG_OUT) && (wr_ptr[1] > TRIG_IN);

  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    req_d = '0;
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      hits_d[i]  = hits_q[i];
      if (!on[i]) begin
        state_d[i] = S_OFF;
        cnt_d[i]   = '0;
      end else begin
        unique case (state_q[i])
          S_OFF:  state_d[i] = S_SYNC;
          S_SYNC: if (bus.out_vs) state_d[i] = S_TRACK;
          S_TRACK: begin
            if (need[i]) begin
              state_d[i] = S_HOLD;
              cnt_d[i]   = HOLD_LEN;
              hits_d[i]  = (hits_q[i] == 8'hFF) ? hits_q[i] : hits_q[i] + 8'd1;
            end
          end
          S_HOLD: begin
            // A level-true need reloads every cycle, so a stuck pointer keeps the core paused.
            if (need[i]) begin
              cnt_d[i]  = HOLD_LEN;
              hits_d[i] = (hits_q[i] == 8'hFF) ? hits_q[i] : hits_q[i] + 8'd1;
            end else if (cnt_q[i] == 8'd1) begin
              state_d[i] = S_TRACK;
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i] = cnt_q[i] - 8'd1;
            end
          end
          default: state_d[i] = S_OFF;
        endcase
      end
      req_d[i] = (state_d[i] == S_HOLD);
    end
    pause_d[0] = req_d[0] | (bus.link_lock & req_d[1]);
    pause_d[1] = req_d[1] | (bus.link_lock & req_d[0]);
  end

  // NOTE: async reset clears pause at once, without waiting for a clock edge.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= S_OFF;
        cnt_q[i]   <= '0;
        hits_q[i]  <= '0;
      end
      pause_q <= '0;
    end else begin
      // NOTE: non-blocking updates keep both cores' registers sampling the same pre-edge values.
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        hits_q[i]  <= hits_d[i];
      end
      pause_q <= pause_d;
    end
  end

  assign bus.pause1 = pause_q[0];
  assign bus.pause2 = pause_q[1];
  assign bus.state1 = state_q[0];
  assign bus.state2 = state_q[1];
  assign bus.hits1  = hits_q[0];
  assign bus.hits2  = hits_q[1];

endmodule
